atmr_vote_sched: RTL and testbench



---
 rtl/atmr_vote_sched.sv | 202 ++++++++++++++++++++
 tb/tb_atmr_vote_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atmr_vote_sched.sv
// Self-test sweep scheduler and majority-vote monitor for ori/mai/men ATMR replicas.
// Optional first-failing-vector capture is compiled in with `define ATMR_FIRST_FAIL_EN.
module atmr_vote_sched #(
  parameter int VEC_W  = 7,
  parameter int OUT_W  = 10,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [VEC_W-1:0]   vec_o,
  input  logic [OUT_W-1:0]   ori_i,
  input  logic [OUT_W-1:0]   mai_i,
  input  logic [OUT_W-1:0]   men_i,
  output logic [OUT_W-1:0]   voted_o,
  output logic               voted_vld,
  output logic [CNT_W-1:0]   err_ori,
  output logic [CNT_W-1:0]   err_mai,
  output logic [CNT_W-1:0]   err_men,
  output logic [VEC_W:0]     unan_cnt,
  output logic               busy,
  output logic               done
`ifdef ATMR_FIRST_FAIL_EN
  ,
  output logic [VEC_W-1:0]   ff_ori,
  output logic [VEC_W-1:0]   ff_mai,
  output logic [VEC_W-1:0]   ff_men,
  output logic [2:0]         ff_vld
`endif
);

  // state | meaning
  // IDLE  | waiting for start, counters hold last results
  // DRIVE | vec_o freshly updated, first settle cycle
  // WAIT  | remaining settle cycles
  // CAPT  | replica outputs sampled, vote and counters updated at cycle end
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [VEC_W-1:0] VEC_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_settle;
  logic [VEC_W-1:0] r_vec;
  logic [OUT_W-1:0] r_voted;
  logic             r_vld;
  logic [CNT_W-1:0] r_err_ori;
  logic [CNT_W-1:0] r_err_mai;
  logic [CNT_W-1:0] r_err_men;
  logic [VEC_W:0]   r_unan;

  logic             w_start_ok;
  logic             w_capt;
  logic             w_last;
  logic             w_settling;
  logic [OUT_W-1:0] w_vote;
  logic             w_err_ori;
  logic             w_err_mai;
  logic             w_err_men;
  logic             w_unan;

  assign w_last     = (r_vec == VEC_LAST);
  assign w_settling = (r_state == S_DRIVE) || (r_state == S_WAIT);
  assign w_vote     = (ori_i & mai_i) | (ori_i & men_i) | (mai_i & men_i);
  assign w_err_ori  = |(ori_i ^ w_vote);
  assign w_err_mai  = |(mai_i ^ w_vote);
  assign w_err_men  = |(men_i ^ w_vote);
  assign w_unan     = (ori_i == mai_i) && (mai_i == men_i);

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_capt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_DRIVE;
          w_start_ok  = 1'b1;
        end
      end
      S_DRIVE, S_WAIT: begin
        if (abort)                 w_state_nxt = S_IDLE;
        else if (r_settle == 4'd1) w_state_nxt = S_CAPT;
        else                       w_state_nxt = S_WAIT;
      end
      S_CAPT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_capt      = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_DRIVE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DRIVE counts as the first settle cycle, so one vector costs SETTLE+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= '0;
      r_vec     <= '0;
      r_voted   <= '0;
      r_vld     <= 1'b0;
      r_err_ori <= '0;
      r_err_mai <= '0;
      r_err_men <= '0;
      r_unan    <= '0;
    end else begin
      r_vld <= w_capt;
      if (w_start_ok) begin
        r_settle  <= SETTLE_L;
        r_vec     <= '0;
        r_err_ori <= '0;
        r_err_mai <= '0;
        r_err_men <= '0;
        r_unan    <= '0;
      end else begin
        if (w_settling && !abort && (r_settle != 4'd1))
          r_settle <= r_settle - 4'd1;
        if (w_capt) begin
          r_voted <= w_vote;
          if (!w_last) begin
            r_vec    <= r_vec + 1'b1;
            r_settle <= SETTLE_L;
          end
          if (w_err_ori && (r_err_ori != CNT_MAX)) r_err_ori <= r_err_ori + 1'b1;
          if (w_err_mai && (r_err_mai != CNT_MAX)) r_err_mai <= r_err_mai + 1'b1;
          if (w_err_men && (r_err_men != CNT_MAX)) r_err_men <= r_err_men + 1'b1;
          if (w_unan) r_unan <= r_unan + 1'b1;
        end
      end
    end
  end

`ifdef ATMR_FIRST_FAIL_EN
  logic [VEC_W-1:0] r_ff_ori;
  logic [VEC_W-1:0] r_ff_mai;
  logic [VEC_W-1:0] r_ff_men;
  logic [2:0]       r_ff_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_ori <= '0;
      r_ff_mai <= '0;
      r_ff_men <= '0;
      r_ff_vld <= '0;
    end else if (w_start_ok) begin
      r_ff_ori <= '0;
      r_ff_mai <= '0;
      r_ff_men <= '0;
      r_ff_vld <= '0;
    end else if (w_capt) begin
      if (w_err_ori && !r_ff_vld[0]) begin
        r_ff_ori    <= r_vec;
        r_ff_vld[0] <= 1'b1;
      end
      if (w_err_mai && !r_ff_vld[1]) begin
        r_ff_mai    <= r_vec;
        r_ff_vld[1] <= 1'b1;
      end
      if (w_err_men && !r_ff_vld[2]) begin
        r_ff_men    <= r_vec;
        r_ff_vld[2] <= 1'b1;
      end
    end
  end

  assign ff_ori = r_ff_ori;
  assign ff_mai = r_ff_mai;
  assign ff_men = r_ff_men;
  assign ff_vld = r_ff_vld;
`endif

  assign vec_o     = r_vec;
  assign voted_o   = r_voted;
  assign voted_vld = r_vld;
  assign err_ori   = r_err_ori;
  assign err_mai   = r_err_mai;
  assign err_men   = r_err_men;
  assign unan_cnt  = r_unan;
  assign busy      = w_settling || (r_state == S_CAPT);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_atmr_vote_sched.sv
// Directed bench for atmr_vote_sched: three instances (default, CNT_W=4, SETTLE=3)
// driven by bench-side replica models; expected values are hand-derived constants.
module tb_atmr_vote_sched;

  logic clk;
  logic rst_n;
  logic [2:0] start_v;
  logic abort_a;
  logic mode_a;
  int   cyc;
  int   sel;
  int   n_chk;
  int   n_err;

  function automatic logic [9:0] pat(input logic [6:0] v);
    return {v[2:0], v} ^ 10'h2C5;
  endfunction

  // instance a: default parameters, men optionally faulted at vector 0x2A
  logic [6:0] vec_a;
  logic [9:0] ori_a, mai_a, men_a, voted_a;
  logic       voted_vld_a, busy_a, done_a;
  logic [7:0] err_ori_a, err_mai_a, err_men_a;
  logic [7:0] unan_a;
  assign ori_a = pat(vec_a);
  assign mai_a = pat(vec_a);
  assign men_a = pat(vec_a) ^ ((mode_a && (vec_a == 7'h2A)) ? 10'h001 : 10'h000);

  // instance b: CNT_W=4, mai always inverted
  logic [6:0] vec_b;
  logic [9:0] ori_b, mai_b, men_b, voted_b;
  logic       voted_vld_b, busy_b, done_b;
  logic [3:0] err_ori_b, err_mai_b, err_men_b;
  logic [7:0] unan_b;
  assign ori_b = pat(vec_b);
  assign mai_b = ~pat(vec_b);
  assign men_b = pat(vec_b);

  // instance c: SETTLE=3, ori/mai lag vec_o by two cycles
  logic [6:0] vec_c, d1_c, d2_c;
  logic [9:0] ori_c, mai_c, men_c, voted_c;
  logic       voted_vld_c, busy_c, done_c;
  logic [7:0] err_ori_c, err_mai_c, err_men_c;
  logic [7:0] unan_c;
  assign ori_c = pat(d2_c);
  assign mai_c = pat(d2_c);
  assign men_c = pat(vec_c);

  logic abort_off;
  assign abort_off = 1'b0;

`ifdef ATMR_FIRST_FAIL_EN
  logic [6:0] ff_ori_a, ff_mai_a, ff_men_a, ff_ori_b, ff_mai_b, ff_men_b, ff_ori_c, ff_mai_c, ff_men_c;
  logic [2:0] ff_vld_a, ff_vld_b, ff_vld_c;
`endif

  atmr_vote_sched u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_a),
    .vec_o(vec_a), .ori_i(ori_a), .mai_i(mai_a), .men_i(men_a),
    .voted_o(voted_a), .voted_vld(voted_vld_a),
    .err_ori(err_ori_a), .err_mai(err_mai_a), .err_men(err_men_a),
    .unan_cnt(unan_a), .busy(busy_a), .done(done_a)
`ifdef ATMR_FIRST_FAIL_EN
    , .ff_ori(ff_ori_a), .ff_mai(ff_mai_a), .ff_men(ff_men_a), .ff_vld(ff_vld_a)
`endif
  );

  atmr_vote_sched #(.CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_off),
    .vec_o(vec_b), .ori_i(ori_b), .mai_i(mai_b), .men_i(men_b),
    .voted_o(voted_b), .voted_vld(voted_vld_b),
    .err_ori(err_ori_b), .err_mai(err_mai_b), .err_men(err_men_b),
    .unan_cnt(unan_b), .busy(busy_b), .done(done_b)
`ifdef ATMR_FIRST_FAIL_EN
    , .ff_ori(ff_ori_b), .ff_mai(ff_mai_b), .ff_men(ff_men_b), .ff_vld(ff_vld_b)
`endif
  );

  atmr_vote_sched #(.SETTLE(3)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_off),
    .vec_o(vec_c), .ori_i(ori_c), .mai_i(mai_c), .men_i(men_c),
    .voted_o(voted_c), .voted_vld(voted_vld_c),
    .err_ori(err_ori_c), .err_mai(err_mai_c), .err_men(err_men_c),
    .unan_cnt(unan_c), .busy(busy_c), .done(done_c)
`ifdef ATMR_FIRST_FAIL_EN
    , .ff_ori(ff_ori_c), .ff_mai(ff_mai_c), .ff_men(ff_men_c), .ff_vld(ff_vld_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    d1_c <= vec_c;
    d2_c <= d1_c;
  end

  logic       m_vld, m_done, m_busy;
  logic [9:0] m_voted;
  always_comb begin
    m_vld = voted_vld_a; m_done = done_a; m_busy = busy_a; m_voted = voted_a;
    case (sel)
      1: begin m_vld = voted_vld_b; m_done = done_b; m_busy = busy_b; m_voted = voted_b; end
      2: begin m_vld = voted_vld_c; m_done = done_c; m_busy = busy_c; m_voted = voted_c; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // start one sweep on instance `which`, check every vote, done timing and pulse count
  task automatic run_sweep(input int which, input int exp_cyc, input string tag);
    int st;
    int nv;
    bit seen;
    sel = which;
    st = cyc;
    start_v = 3'b000;
    start_v[which] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    nv = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (m_vld) begin
        chk({tag, "_vote"}, 64'(m_voted), 64'(pat(7'(nv))));
        nv++;
      end
      if (m_done) begin
        seen = 1'b1;
        chk({tag, "_done_cyc"}, 64'(cyc - st), 64'(exp_cyc));
        chk({tag, "_busy_at_done"}, 64'(m_busy), 64'd0);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_vld_pulses"}, 64'(nv), 64'd128);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(m_done), 64'd0);
  endtask

  initial begin
    int st;
    int nd;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start_v = 3'b000; abort_a = 1'b0; mode_a = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_vec", 64'(vec_a), 64'd0);
    chk("rst_flags", 64'({busy_a, done_a, voted_vld_a}), 64'd0);
    chk("rst_cnt", 64'({err_ori_a, err_mai_a, err_men_a, unan_a}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // identical replicas
    run_sweep(0, 257, "clean");
    chk("clean_err", 64'({err_ori_a, err_mai_a, err_men_a}), 64'd0);
    chk("clean_unan", 64'(unan_a), 64'd128);
    chk("clean_vec_hold", 64'(vec_a), 64'h7F);

    // abort in the CAPT cycle of vector 0x10, with an ignored start earlier
    mode_a = 1'b1;
    st = cyc;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    for (int i = 0; i < 200 && vec_a != 7'h05; i++) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    for (int i = 0; i < 200 && vec_a != 7'h10; i++) @(negedge clk);
    chk("ign_start_cyc", 64'(cyc - st), 64'd33);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_vld", 64'(voted_vld_a), 64'd0);
    chk("abort_vec", 64'(vec_a), 64'h10);
    chk("abort_unan", 64'(unan_a), 64'd16);
    nd = int'(done_a);
    repeat (8) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    chk("abort_frozen", 64'(unan_a), 64'd16);

    // start and abort together in IDLE
    start_v[0] = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_v = 3'b000; abort_a = 1'b0;
    chk("sa_idle_busy", 64'(busy_a), 64'd0);
    chk("sa_idle_unan", 64'(unan_a), 64'd16);

    // single-vector fault on men; fresh start clears the partial counts
    run_sweep(0, 257, "men_fault");
    chk("men_fault_err_men", 64'(err_men_a), 64'd1);
    chk("men_fault_err_om", 64'({err_ori_a, err_mai_a}), 64'd0);
    chk("men_fault_unan", 64'(unan_a), 64'd127);
`ifdef ATMR_FIRST_FAIL_EN
    chk("men_fault_ff_men", 64'(ff_men_a), 64'h2A);
    chk("men_fault_ff_vld", 64'(ff_vld_a), 64'b100);
`endif

    // inverted mai with 4-bit counters
    run_sweep(1, 257, "c4");
    chk("c4_err_mai_sat", 64'(err_mai_b), 64'd15);
    chk("c4_err_om", 64'({err_ori_b, err_men_b}), 64'd0);
    chk("c4_unan", 64'(unan_b), 64'd0);
`ifdef ATMR_FIRST_FAIL_EN
    chk("c4_ff_mai", 64'(ff_mai_b), 64'h00);
    chk("c4_ff_vld", 64'(ff_vld_b), 64'b010);
`endif

    // SETTLE=3 with slow replicas
    run_sweep(2, 513, "s3");
    chk("s3_err", 64'({err_ori_c, err_mai_c, err_men_c}), 64'd0);
    chk("s3_unan", 64'(unan_c), 64'd128);

    // asynchronous reset during WAIT
    st = cyc;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy_c), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_c", {vec_c, busy_c, done_c, voted_vld_c, voted_c, err_ori_c, err_mai_c, err_men_c, unan_c}, 64'd0);
    chk("async_rst_a", 64'({err_men_a, unan_a, vec_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'({busy_c, vec_c}), 64'd0);
    run_sweep(2, 513, "s3_post_rst");
    chk("s3_post_rst_unan", 64'(unan_c), 64'd128);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
